// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW and branch hazard steering
// plus the SRAM start/ready sequencer that freezes the back end during memory access.
module pipeline_hazard_ctrl #(
  parameter int REG_FILE_DEPTH = 4,
  parameter int FWD_EN         = 1,
  parameter int TIMEOUT        = 64,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_FILE_DEPTH-1:0] src1,
  input  logic [REG_FILE_DEPTH-1:0] src2,
  input  logic                      two_src,
  input  logic [REG_FILE_DEPTH-1:0] ex_dst,
  input  logic                      ex_wb_en,
  input  logic                      ex_mem_read,
  input  logic [REG_FILE_DEPTH-1:0] mem_dst,
  input  logic                      mem_wb_en,
  input  logic                      branch_taken,
  input  logic                      mem_req,
  input  logic                      sram_ready,
  output logic                      freeze_if,
  output logic                      flush_if,
  output logic                      freeze_id,
  output logic                      flush_id,
  output logic                      mem_stall,
  output logic                      sram_start,
  output logic                      mem_timeout,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic haz_fwd, haz_nofwd, haz;

  // RAW detection: with forwarding only a load in EX cannot be bypassed in time.
  always_comb begin
    m1_ex     = (src1 == ex_dst);
    m2_ex     = two_src && (src2 == ex_dst);
    m1_mem    = (src1 == mem_dst);
    m2_mem    = two_src && (src2 == mem_dst);
    haz_fwd   = ex_wb_en && ex_mem_read && (m1_ex || m2_ex);
    haz_nofwd = (ex_wb_en && (m1_ex || m2_ex)) || (mem_wb_en && (m1_mem || m2_mem));
    haz       = (FWD_EN != 0) ? haz_fwd : haz_nofwd;
  end

  // Start/stall are masked while rst is held so a pending mem_req cannot launch an access.
  always_comb begin
    sram_start = !rst && (state_q == S_IDLE) && mem_req;
    mem_stall  = !rst && (((state_q == S_IDLE) && mem_req) || (state_q == S_WAIT));
  end

  // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    freeze_if = 1'b0;
    flush_if  = 1'b0;
    freeze_id = 1'b0;
    flush_id  = 1'b0;
    if (mem_stall) begin
      freeze_if = 1'b1;
      freeze_id = 1'b1;
    end else if (branch_taken) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (haz) begin
      freeze_if = 1'b1;
      flush_id  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        // Ready on the final allowed cycle still counts as a completed access.
        if (sram_ready) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three controller instances share one input set (forwarding on,
// forwarding off, short timeout with 2-bit counter) and are checked step by step.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1, src2, ex_dst, mem_dst;
  logic       two_src, ex_wb_en, ex_mem_read, mem_wb_en;
  logic       branch_taken, mem_req, sram_ready;

  logic        f_freeze_if, f_flush_if, f_freeze_id, f_flush_id, f_mem_stall, f_sram_start, f_mem_timeout;
  logic [15:0] f_stall_cnt;
  logic        n_freeze_if, n_flush_if, n_freeze_id, n_flush_id, n_mem_stall, n_sram_start, n_mem_timeout;
  logic [15:0] n_stall_cnt;
  logic        t_freeze_if, t_flush_if, t_freeze_id, t_flush_id, t_mem_stall, t_sram_start, t_mem_timeout;
  logic [1:0]  t_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_FILE_DEPTH(4), .FWD_EN(1), .TIMEOUT(64), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready),
    .freeze_if(f_freeze_if), .flush_if(f_flush_if), .freeze_id(f_freeze_id), .flush_id(f_flush_id),
    .mem_stall(f_mem_stall), .sram_start(f_sram_start), .mem_timeout(f_mem_timeout), .stall_cnt(f_stall_cnt)
  );

  pipeline_hazard_ctrl #(.REG_FILE_DEPTH(4), .FWD_EN(0), .TIMEOUT(64), .CNT_W(16)) dut_n (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready),
    .freeze_if(n_freeze_if), .flush_if(n_flush_if), .freeze_id(n_freeze_id), .flush_id(n_flush_id),
    .mem_stall(n_mem_stall), .sram_start(n_sram_start), .mem_timeout(n_mem_timeout), .stall_cnt(n_stall_cnt)
  );

  pipeline_hazard_ctrl #(.REG_FILE_DEPTH(4), .FWD_EN(1), .TIMEOUT(4), .CNT_W(2)) dut_t (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready),
    .freeze_if(t_freeze_if), .flush_if(t_flush_if), .freeze_id(t_freeze_id), .flush_id(t_flush_id),
    .mem_stall(t_mem_stall), .sram_start(t_sram_start), .mem_timeout(t_mem_timeout), .stall_cnt(t_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run a further 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    src1 = '0; src2 = '0; two_src = 1'b0;
    ex_dst = '0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
    mem_dst = '0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    settle();
    check("rst_freeze_if", {31'd0, f_freeze_if}, 32'd0);
    check("rst_flush_id",  {31'd0, f_flush_id},  32'd0);
    check("rst_mem_stall", {31'd0, f_mem_stall}, 32'd0);
    check("rst_timeout",   {31'd0, f_mem_timeout}, 32'd0);
    check("rst_stall_cnt", {16'd0, f_stall_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Load-use in EX: forwarding instance stalls with a bubble.
    ex_dst = 4'd3; ex_wb_en = 1'b1; ex_mem_read = 1'b1; src1 = 4'd3;
    settle();
    check("lu_f_freeze_if", {31'd0, f_freeze_if}, 32'd1);
    check("lu_f_flush_id",  {31'd0, f_flush_id},  32'd1);
    check("lu_f_freeze_id", {31'd0, f_freeze_id}, 32'd0);
    check("lu_f_flush_if",  {31'd0, f_flush_if},  32'd0);
    check("lu_n_freeze_if", {31'd0, n_freeze_if}, 32'd1);
    tick();  // counts: f=1 n=1 t=1
    ex_mem_read = 1'b0;
    settle();
    check("alu_f_freeze_if", {31'd0, f_freeze_if}, 32'd0);
    check("alu_f_flush_id",  {31'd0, f_flush_id},  32'd0);
    check("alu_n_freeze_if", {31'd0, n_freeze_if}, 32'd1);
    tick();  // counts: f=1 n=2 t=1
    check("alu_f_stall_cnt", {16'd0, f_stall_cnt}, 32'd1);

    // MEM-stage RAW on src2 only matters when the instruction reads src2.
    ex_wb_en = 1'b0; ex_dst = 4'd0;
    mem_dst = 4'd5; mem_wb_en = 1'b1; src1 = 4'd1; src2 = 4'd5; two_src = 1'b0;
    settle();
    check("mem_1src_n_freeze", {31'd0, n_freeze_if}, 32'd0);
    tick();
    two_src = 1'b1;
    settle();
    check("mem_2src_n_freeze", {31'd0, n_freeze_if}, 32'd1);
    check("mem_2src_n_flush",  {31'd0, n_flush_id},  32'd1);
    check("mem_2src_f_freeze", {31'd0, f_freeze_if}, 32'd0);
    tick();  // counts: f=1 n=3 t=1
    check("mem_2src_n_cnt", {16'd0, n_stall_cnt}, 32'd3);
    mem_wb_en = 1'b0; two_src = 1'b0; src2 = 4'd0;

    // Taken branch overrides a concurrent load-use hazard.
    ex_dst = 4'd3; ex_wb_en = 1'b1; ex_mem_read = 1'b1; src1 = 4'd3; branch_taken = 1'b1;
    settle();
    check("br_flush_if",  {31'd0, f_flush_if},  32'd1);
    check("br_flush_id",  {31'd0, f_flush_id},  32'd1);
    check("br_freeze_if", {31'd0, f_freeze_if}, 32'd0);
    check("br_freeze_id", {31'd0, f_freeze_id}, 32'd0);
    tick();
    idle_inputs();

    // SRAM access: ready on WAIT cycle 4 -> 5 stalled cycles then DONE.
    mem_req = 1'b1;
    settle();
    check("acc_start",     {31'd0, f_sram_start}, 32'd1);
    check("acc_stall_c0",  {31'd0, f_mem_stall},  32'd1);
    check("acc_freeze_id", {31'd0, f_freeze_id},  32'd1);
    tick();  // WAIT 1
    check("acc_start_w1", {31'd0, f_sram_start}, 32'd0);
    check("acc_stall_w1", {31'd0, f_mem_stall},  32'd1);
    tick();  // WAIT 2
    branch_taken = 1'b1;
    settle();
    check("acc_br_flush_if",  {31'd0, f_flush_if},  32'd0);
    check("acc_br_freeze_if", {31'd0, f_freeze_if}, 32'd1);
    tick();  // WAIT 3
    branch_taken = 1'b0;
    tick();  // WAIT 4
    sram_ready = 1'b1;
    settle();
    check("acc_stall_w4", {31'd0, f_mem_stall}, 32'd1);
    tick();  // DONE, mem_req still high
    sram_ready = 1'b0;
    settle();
    check("done_stall",     {31'd0, f_mem_stall},  32'd0);
    check("done_start",     {31'd0, f_sram_start}, 32'd0);
    check("done_freeze_if", {31'd0, f_freeze_if},  32'd0);
    check("done_f_cnt",     {16'd0, f_stall_cnt},  32'd6);
    check("done_t_cnt_sat", {30'd0, t_stall_cnt},  32'd3);
    check("done_t_no_tmo",  {31'd0, t_mem_timeout}, 32'd0);
    mem_req = 1'b0;
    tick();  // back to IDLE
    check("idle_stall", {31'd0, f_mem_stall}, 32'd0);

    // No ready: short-timeout instance abandons after 4 WAIT cycles.
    mem_req = 1'b1;
    tick();  // WAIT 1
    mem_req = 1'b0;
    tick();  // WAIT 2
    tick();  // WAIT 3
    tick();  // WAIT 4
    check("tmo_stall_w4", {31'd0, t_mem_stall}, 32'd1);
    check("tmo_flag_w4",  {31'd0, t_mem_timeout}, 32'd0);
    tick();  // dut_t DONE, dut_f still WAIT
    check("tmo_done_stall", {31'd0, t_mem_stall},   32'd0);
    check("tmo_flag",       {31'd0, t_mem_timeout}, 32'd1);
    check("tmo_f_waiting",  {31'd0, f_mem_stall},   32'd1);
    check("tmo_f_no_flag",  {31'd0, f_mem_timeout}, 32'd0);
    sram_ready = 1'b1;
    tick();  // dut_f DONE, dut_t IDLE ignores ready
    sram_ready = 1'b0;
    check("tmo_sticky", {31'd0, t_mem_timeout}, 32'd1);
    check("tmo_t_cnt",  {30'd0, t_stall_cnt},   32'd3);
    tick();  // all IDLE

    // Reset in the middle of an access with mem_req still asserted.
    mem_req = 1'b1;
    tick();  // WAIT 1
    tick();  // WAIT 2
    #2;
    rst = 1'b1;
    settle();
    check("mrst_stall",     {31'd0, f_mem_stall},   32'd0);
    check("mrst_start",     {31'd0, f_sram_start},  32'd0);
    check("mrst_freeze_if", {31'd0, f_freeze_if},   32'd0);
    check("mrst_cnt",       {16'd0, f_stall_cnt},   32'd0);
    check("mrst_t_tmo",     {31'd0, t_mem_timeout}, 32'd0);
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_stall", {31'd0, f_mem_stall}, 32'd0);
    check("post_rst_cnt",   {16'd0, f_stall_cnt}, 32'd0);
    tick();
    check("post_rst_idle",  {31'd0, f_mem_stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
